// File: rtl/candy_pkg.sv
// Shared types and constants for the candy dispenser: scheduler states,
// servo/counter widths and default servo timings used by the PWM side too.
package candy_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXTEND   = 3'd1,
    DWELL    = 3'd2,
    RETRACT  = 3'd3,
    COOLDOWN = 3'd4
  } disp_state_t;

  localparam int SERVO_W = 11;
  localparam int CNT_W   = 16;

  localparam int DEF_RETRACT_US  = 1000;
  localparam int DEF_EXTEND_US   = 2000;
  localparam int DEF_TRAVEL_MS   = 1000;
  localparam int DEF_DWELL_MS    = 500;
  localparam int DEF_COOLDOWN_MS = 2000;

endpackage

// File: rtl/ms_timer.sv
// Millisecond phase timer: reloads on load, then pulses expire on the last
// cycle of a dur_ms * CLK_HZ/1000 cycle interval.
module ms_timer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] dur_ms,
  output logic        expire
);

  localparam int PRE = CLK_HZ / 1000;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(PRE - 1);

  logic [PW-1:0] pre;
  logic [11:0]   ms;
  logic          run;

  // Combinational so the owner can leave its state on exactly the last cycle.
  assign expire = run && (pre == '0) && (ms == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      ms  <= '0;
      run <= 1'b0;
    end else if (load) begin
      pre <= PRE_TOP;
      ms  <= dur_ms - 12'd1;
      run <= 1'b1;
    end else if (run) begin
      if (expire) begin
        run <= 1'b0;
      end else if (pre == '0) begin
        pre <= PRE_TOP;
        ms  <= ms - 12'd1;
      end else begin
        pre <= pre - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Servo dispense sequencer shared by N_REQ requesters: per-requester request
// queues, round-robin grant, and the extend/dwell/retract/cooldown cycle.
module dispense_scheduler
  import candy_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_REQ       = 2,
  parameter int RETRACT_US  = DEF_RETRACT_US,
  parameter int EXTEND_US   = DEF_EXTEND_US,
  parameter int TRAVEL_MS   = DEF_TRAVEL_MS,
  parameter int DWELL_MS    = DEF_DWELL_MS,
  parameter int COOLDOWN_MS = DEF_COOLDOWN_MS,
  parameter int MAX_PENDING = 3
) (
  input  logic                     clk_50m,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [SERVO_W-1:0]       pwm_width,
  output logic                     pwm_active,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     done,
  output logic [N_REQ-1:0]         req_drop,
  output logic [CNT_W-1:0]         dispense_count
);

  localparam int GW = $clog2(N_REQ);
  localparam int PW = 3;
  localparam logic [11:0] TRAVEL_D = 12'(TRAVEL_MS);
  localparam logic [11:0] DWELL_D  = 12'(DWELL_MS);
  localparam logic [11:0] COOL_D   = 12'(COOLDOWN_MS);

  disp_state_t state, nxt;

  logic [N_REQ-1:0]         req_q, edge_det, gnt_vec;
  logic [N_REQ-1:0][PW-1:0] pend;
  logic [GW-1:0]            last_grant, pick, cand;
  logic                     found, load, expire;
  logic [11:0]              dur;

  assign edge_det = req & ~req_q;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % N_REQ);
      if (!found && pend[cand] != '0) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    dur     = '0;
    gnt_vec = '0;
    unique case (state)
      IDLE: if (found) begin
        nxt           = EXTEND;
        gnt_vec[pick] = 1'b1;
        load          = 1'b1;
        dur           = TRAVEL_D;
      end
      EXTEND: if (expire) begin
        nxt  = DWELL;
        load = 1'b1;
        dur  = DWELL_D;
      end
      DWELL: if (expire) begin
        nxt  = RETRACT;
        load = 1'b1;
        dur  = TRAVEL_D;
      end
      RETRACT: if (expire) begin
        nxt  = COOLDOWN;
        load = 1'b1;
        dur  = COOL_D;
      end
      COOLDOWN: if (expire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  ms_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clk    (clk_50m),
    .rst    (rst),
    .load   (load),
    .dur_ms (dur),
    .expire (expire)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pwm_width      <= SERVO_W'(RETRACT_US);
      pwm_active     <= 1'b0;
      busy           <= 1'b0;
      grant_id       <= '0;
      last_grant     <= GW'(N_REQ - 1);
      done           <= 1'b0;
      dispense_count <= '0;
    end else begin
      state      <= nxt;
      pwm_width  <= (nxt == EXTEND || nxt == DWELL) ? SERVO_W'(EXTEND_US)
                                                    : SERVO_W'(RETRACT_US);
      pwm_active <= (nxt == EXTEND || nxt == DWELL || nxt == RETRACT);
      busy       <= (nxt != IDLE);
      done       <= (state == RETRACT) && (nxt == COOLDOWN);
      if (gnt_vec != '0) begin
        grant_id   <= pick;
        last_grant <= pick;
      end
      if (state == RETRACT && nxt == COOLDOWN && dispense_count != '1)
        dispense_count <= dispense_count + 1'b1;
    end
  end

  // A new edge in the grant cycle cancels against the grant's decrement.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      pend     <= '0;
      req_drop <= '0;
    end else begin
      req_q <= req;
      for (int i = 0; i < N_REQ; i++) begin
        req_drop[i] <= 1'b0;
        if (edge_det[i] && !gnt_vec[i]) begin
          if (pend[i] == PW'(MAX_PENDING)) req_drop[i] <= 1'b1;
          else                             pend[i]     <= pend[i] + 1'b1;
        end else if (gnt_vec[i] && !edge_det[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Sequences the candy-dispenser servo through a full extend, dwell, retract and cooldown dispense cycle, and shares that single servo between `N_REQ` requesters (button, coin slot, remote trigger) with round-robin arbitration. It sits between the debounced request sources and the servo PWM generator. It supplies the target pulse width in microseconds and a gate that says when pulses must be sent.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency. Must be a multiple of 1000.
- `N_REQ`, default 2: number of requesters, 2..8.
- `RETRACT_US`, default 1000: servo pulse width for the retracted position.
- `EXTEND_US`, default 2000: servo pulse width for the extended position.
- `TRAVEL_MS`, default 1000: time allowed for servo travel in each direction.
- `DWELL_MS`, default 500: hold time at the extended position.
- `COOLDOWN_MS`, default 2000: minimum gap between dispenses.
- `MAX_PENDING`, default 3: per-requester queue depth, 1..7.

Ports:
- `clk_50m` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: one level per requester, already synchronized and debounced. Each rising edge is one dispense request.
- `pwm_width` out 11: target pulse width in µs.
- `pwm_active` out 1: the PWM generator must emit pulses while this is high.
- `busy` out 1: high in every state other than IDLE.
- `grant_id` out $clog2(N_REQ): requester being served.
- `done` out 1: one-cycle pulse when the retract phase completes.
- `req_drop` out N_REQ: one-cycle pulse when a request is discarded because that requester's queue is full.
- `dispense_count` out 16: completed dispenses, saturating.

## Operation
Request capture:
- Edge detect is `req & ~req_q`.
- On a detected edge, `pend[i]` increments at that same clock edge.
- If `pend[i] == MAX_PENDING`, the request is discarded and `req_drop[i]` pulses for one cycle.
- If requester `i` sees a new edge in the same cycle it is granted, the increment and decrement cancel. There is no drop.

State machine:
- IDLE
  - Outputs: `pwm_width = RETRACT_US`, `pwm_active = 0`.
  - If any `pend != 0`, grant the first non-zero requester searching round-robin from `last_grant + 1` (modulo N_REQ).
  - On grant: load `grant_id`, decrement that `pend`, and go to EXTEND.
- EXTEND
  - Outputs: `pwm_width = EXTEND_US`, `pwm_active = 1`.
  - Lasts TRAVEL_MS, then goes to DWELL.
- DWELL
  - Outputs: `pwm_width = EXTEND_US`, `pwm_active = 1`.
  - Lasts DWELL_MS, then goes to RETRACT.
- RETRACT
  - Outputs: `pwm_width = RETRACT_US`, `pwm_active = 1`.
  - Lasts TRAVEL_MS.
  - On exit: `done` pulses, `dispense_count` increments (holds at 0xFFFF), and the state goes to COOLDOWN.
- COOLDOWN
  - Outputs: `pwm_width = RETRACT_US`, `pwm_active = 0`.
  - Lasts COOLDOWN_MS, then goes to IDLE.

Other rules:
- `grant_id` holds its value from grant until the next grant.
- Requests keep queuing while `busy` is high.
- All outputs are registered.

## Timing
- Reset values (applied immediately and asynchronously):
  - state IDLE, `pwm_width = RETRACT_US`, `pwm_active = 0`, `busy = 0`, `grant_id = 0`, `done = 0`, `req_drop = 0`, `dispense_count = 0`.
  - all `pend = 0`, `req_q = 0`.
  - `last_grant = N_REQ-1`, so requester 0 has first priority.
- Reset mid-cycle abandons the dispense and flushes all queues.
- Request latency: a `req` edge is sampled at edge e, so `pend` is non-zero after e. If the block is IDLE, it enters EXTEND at edge e+1, and `busy`/`pwm_active` go high after e+1.
- Phase timing:
  - Each timed state lasts exactly `D * CLK_HZ/1000` cycles.
  - The prescaler and ms counter both reload on state entry, so there is no phase error from a free-running tick.
  - A zero duration is illegal.
- Full cycle is `(2*TRAVEL_MS + DWELL_MS + COOLDOWN_MS) * CLK_HZ/1000` cycles, plus one IDLE cycle per grant.
- `done` is high for the first cycle of COOLDOWN.

## Structure
- Package `candy_pkg` holds:
  - `disp_state_t` enum: IDLE, EXTEND, DWELL, RETRACT, COOLDOWN.
  - `SERVO_W = 11` and `CNT_W = 16`.
  - Default µs/ms constants shared with the PWM generator.
- Sub-module `ms_timer`:
  - Ports: `load`, `dur_ms[11:0]`, `expire`.
  - Contains the `CLK_HZ/1000` prescaler and the ms down-counter.
  - `expire` is a one-cycle pulse.
- Arbiter and FSM stay in `dispense_scheduler`.

## Test plan
All scenarios use `CLK_HZ = 2000` (2 cycles per ms), `TRAVEL_MS = 3`, `DWELL_MS = 2`, `COOLDOWN_MS = 4`.

1. Single request on `req[0]`:
   - `busy` rises 2 edges later.
   - `pwm_width` reads 2000 for 10 cycles, then 1000.
   - `done` pulses after 16 cycles, `dispense_count = 1`, `busy` low after 24 cycles.
2. `req[0]` and `req[1]` rise in the same cycle: grants go 0 then 1, with the second EXTEND starting 1 cycle after the first COOLDOWN ends.
3. Four edges on `req[1]` while busy, with `MAX_PENDING = 3`: the fourth edge gives `req_drop[1]` for 1 cycle, and exactly 3 further dispenses occur.
4. `rst` asserted mid-DWELL: outputs take reset values immediately, and queued requests are not served.
5. `req[0]` edge in its own grant cycle: `pend[0]` is unchanged and `req_drop` stays 0.
6. Force `dispense_count = 0xFFFF`, then complete one dispense: count stays 0xFFFF and `done` still pulses.
